// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction memory address from fetch_pc,
// buffers {pc, word} pairs in a shift-style prefetch queue and hands them to decode.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    output logic        imem_read_write,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_word,
    output logic        fault,
    output logic [31:0] fault_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    entry_t           q   [DEPTH];
    entry_t           q_n [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] wr_idx_c;
    logic [31:0]      fetch_pc;
    logic             push_c;
    logic             pop_c;

    assign imem_address    = fetch_pc;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = 32'h0;
    assign inst_pc         = q[0].pc;
    assign inst_word       = q[0].word;

    // Queue next state: entry 0 is always the head, so a pop shifts everything down.
    always_comb begin
        pop_c    = inst_valid && inst_ready && !redirect_valid;
        push_c   = !fault && !redirect_valid && ((count < CNT_W'(DEPTH)) || pop_c);
        wr_idx_c = count - CNT_W'(pop_c);
        count_n  = count + CNT_W'(push_c) - CNT_W'(pop_c);
        q_n      = q;
        if (pop_c) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                q_n[i] = q[i + 1];
            end
        end
        if (push_c) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_idx_c == CNT_W'(i)) begin
                    q_n[i] = {fetch_pc, imem_data_out};
                end
            end
        end
    end

    // Redirect outranks push/pop; a misaligned target latches the first fault address only.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            count      <= '0;
            inst_valid <= 1'b0;
            fault      <= 1'b0;
            fault_pc   <= 32'h0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q[i] <= '0;
            end
        end else if (redirect_valid) begin
            count      <= '0;
            inst_valid <= 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                fetch_pc <= redirect_target;
            end else begin
                fault <= 1'b1;
                if (!fault) begin
                    fault_pc <= redirect_target;
                end
            end
        end else begin
            q          <= q_n;
            count      <= count_n;
            inst_valid <= (count_n != '0);
            if (push_c) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a scoreboard queue holds the expected accepted
// {pc, word} stream, a negedge monitor checks every handshake against it.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_word;
    logic        fault;
    logic [31:0] fault_pc;

    int   checks   = 0;
    int   errors   = 0;
    int   accepts  = 0;
    int   acc0     = 0;
    exp_t exp_q[$];

    instr_fetch dut (
        .clock           (clock),
        .reset           (reset),
        .imem_address    (imem_address),
        .imem_read_write (imem_read_write),
        .imem_data_in    (imem_data_in),
        .imem_data_out   (imem_data_out),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_pc         (inst_pc),
        .inst_word       (inst_word),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    always #5 clock = ~clock;

    // Instruction memory model: two program words, a distinct pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h0000_0013;
            32'h0100_0004: return 32'h0010_0093;
            default:       return {a[15:0] ^ 16'h5a5a, a[31:16]};
        endcase
    endfunction

    always_comb imem_data_out = mem_word(imem_address);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = start + 32'(4 * i);
            exp_q.push_back({a, mem_word(a)});
        end
    endtask

    // Monitor: every transfer must match the next expected pair.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            accepts++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept: got pc %h with no expected entry", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("accept_pc", inst_pc, e.pc);
                chk("accept_word", inst_word, e.word);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset state and constant outputs
        tick();
        tick();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", imem_address, RESET_PC);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'h0);
        chk("rst_rw", 32'(imem_read_write), 32'd0);
        chk("rst_data_in", imem_data_in, 32'h0);

        // Basic fetch with ready held high
        expect_seq(RESET_PC, 16);
        reset      = 1'b0;
        inst_ready = 1'b1;
        tick();
        chk("c1_valid", 32'(inst_valid), 32'd1);
        chk("c1_pc", inst_pc, 32'h0100_0000);
        chk("c1_word", inst_word, 32'h0000_0013);
        tick();
        chk("c2_pc", inst_pc, 32'h0100_0004);
        chk("c2_word", inst_word, 32'h0010_0093);

        // Backpressure from a fresh reset: queue fills, address holds
        reset      = 1'b1;
        inst_ready = 1'b0;
        tick();
        expect_seq(RESET_PC, 16);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_addr_hold", imem_address, 32'h0100_0008);
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_head", inst_pc, 32'h0100_0000);
        acc0       = accepts;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_pc", inst_pc, 32'h0100_0000 + 32'(4 * (i + 1)));
            chk("drain_addr", imem_address, 32'h0100_0008 + 32'(4 * (i + 1)));
        end
        chk("drain_rate", 32'(accepts - acc0), 32'd4);

        // Redirect while full with ready high: head discarded
        acc0            = accepts;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0040;
        expect_seq(32'h0100_0040, 16);
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(inst_valid), 32'd0);
        chk("redir_addr", imem_address, 32'h0100_0040);
        chk("redir_no_accept", 32'(accepts - acc0), 32'd0);
        tick();
        chk("redir_tgt_valid", 32'(inst_valid), 32'd1);
        chk("redir_tgt_pc", inst_pc, 32'h0100_0040);
        chk("redir_tgt_word", inst_word, mem_word(32'h0100_0040));

        // Misaligned redirect: sticky fault, first address kept
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0042;
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h0100_0042);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        chk("mis_addr_hold", imem_address, 32'h0100_0044);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mis_stay_empty", 32'(inst_valid), 32'd0);
        end
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0044;
        tick();
        redirect_valid = 1'b0;
        chk("mis2_fault", 32'(fault), 32'd1);
        chk("mis2_fault_pc", fault_pc, 32'h0100_0042);
        tick();
        chk("mis2_valid", 32'(inst_valid), 32'd0);
        reset      = 1'b1;
        inst_ready = 1'b0;
        tick();
        reset = 1'b0;
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_fault_pc", fault_pc, 32'h0);
        chk("clr_addr", imem_address, RESET_PC);

        // Reset mid-operation, with a redirect on the same edge
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_00F8;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_addr", imem_address, 32'h0100_0100);
        chk("pre_rst_valid", 32'(inst_valid), 32'd1);
        chk("pre_rst_pc", inst_pc, 32'h0100_00F8);
        reset           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0100_0200;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        chk("mid_rst_valid", 32'(inst_valid), 32'd0);
        chk("mid_rst_addr", imem_address, RESET_PC);
        chk("mid_rst_fault", 32'(fault), 32'd0);

        // Address wrap at the top of the 32-bit space
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        inst_ready      = 1'b1;
        expect_seq(32'hFFFF_FFFC, 4);
        tick();
        redirect_valid = 1'b0;
        chk("wrap_valid0", 32'(inst_valid), 32'd0);
        chk("wrap_addr", imem_address, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        chk("wrap_word0", inst_word, mem_word(32'hFFFF_FFFC));
        tick();
        chk("wrap_pc1", inst_pc, 32'h0000_0000);
        chk("wrap_fault", 32'(fault), 32'd0);
        inst_ready = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
